// File: rtl/fadd_unpack.sv
// fadd_unpack: operand front end of the binary32 add/sub pipeline.
// Unpacks two raw operands, classifies special values, orders them by
// magnitude and computes the alignment shift, through a two-stage
// valid/ready pipeline with full throughput and backpressure.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (op_a, op_b, sub)
//   out_valid/out_ready  result handshake
//   sign_big/small, exp_big, mant_big/small, shift_amt, eff_sub,
//   special, special_result   ordered/unpacked operand bundle
module fadd_unpack #(
  parameter int unsigned SHIFT_MAX = 26,
  parameter int unsigned SHW       = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    op_a,
  input  logic [31:0]    op_b,
  input  logic           sub,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sign_big,
  output logic           sign_small,
  output logic [7:0]     exp_big,
  output logic [23:0]    mant_big,
  output logic [23:0]    mant_small,
  output logic [SHW-1:0] shift_amt,
  output logic           eff_sub,
  output logic           special,
  output logic [31:0]    special_result
);

  localparam int unsigned EW = 8;
  localparam int unsigned MW = 24;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // One unpacked operand as held in stage 1.
  typedef struct packed {
    logic          sign;   // effective sign
    logic [EW-1:0] exp_f;  // raw exponent field (magnitude compare)
    logic [EW-1:0] exp_e;  // effective exponent (denormals use 1)
    logic [MW-1:0] mant;   // {hidden, frac}
    logic          zero;
    logic          inf;
    logic          nan;
  } opnd_t;

  function automatic opnd_t unpack(input logic [31:0] w, input logic flip);
    opnd_t o;
    logic  exp_zero;
    logic  exp_ones;
    logic  frac_zero;
    exp_zero  = (w[30:23] == '0);
    exp_ones  = (w[30:23] == '1);
    frac_zero = (w[22:0] == '0);
    o.sign  = w[31] ^ flip;
    o.exp_f = w[30:23];
    o.exp_e = exp_zero ? EW'(1) : w[30:23];
    o.mant  = {~exp_zero, w[22:0]};
    o.zero  = exp_zero & frac_zero;
    o.inf   = exp_ones & frac_zero;
    o.nan   = exp_ones & ~frac_zero;
    return o;
  endfunction

  // Handshake enables.
  logic  s1_valid_q;
  opnd_t s1_a_q, s1_b_q;
  logic  en1, en2;

  assign en2      = ~out_valid | out_ready;
  assign en1      = ~s1_valid_q | en2;
  assign in_ready = en1;

  // Stage 1: unpack.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (en1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q <= unpack(op_a, 1'b0);
        s1_b_q <= unpack(op_b, sub);
      end
    end
  end

  // Stage 2 combinational: order, shift, classify.
  opnd_t         big_c, small_c;
  logic [EW-1:0] diff_c;
  logic [SHW-1:0] shift_c;
  logic          special_c;
  logic [31:0]   special_res_c;

  always_comb begin
    big_c         = s1_a_q;
    small_c       = s1_b_q;
    // A wins ties so that x - x orders deterministically.
    if ({s1_a_q.exp_f, s1_a_q.mant[MW-2:0]} < {s1_b_q.exp_f, s1_b_q.mant[MW-2:0]}) begin
      big_c   = s1_b_q;
      small_c = s1_a_q;
    end
    // big has exp field >= small, so effective exponents never underflow.
    diff_c  = big_c.exp_e - small_c.exp_e;
    shift_c = (diff_c > EW'(SHIFT_MAX)) ? SHW'(SHIFT_MAX) : SHW'(diff_c);

    special_c     = 1'b0;
    special_res_c = '0;
    if (s1_a_q.nan | s1_b_q.nan) begin
      special_c     = 1'b1;
      special_res_c = QNAN;
    end else if (s1_a_q.inf & s1_b_q.inf & (s1_a_q.sign != s1_b_q.sign)) begin
      special_c     = 1'b1;
      special_res_c = QNAN;
    end else if (s1_a_q.inf) begin
      special_c     = 1'b1;
      special_res_c = {s1_a_q.sign, 8'hFF, 23'd0};
    end else if (s1_b_q.inf) begin
      special_c     = 1'b1;
      special_res_c = {s1_b_q.sign, 8'hFF, 23'd0};
    end else if (s1_a_q.zero & s1_b_q.zero) begin
      special_c     = 1'b1;
      special_res_c = {s1_a_q.sign & s1_b_q.sign, 31'd0};
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      sign_big       <= 1'b0;
      sign_small     <= 1'b0;
      exp_big        <= '0;
      mant_big       <= '0;
      mant_small     <= '0;
      shift_amt      <= '0;
      eff_sub        <= 1'b0;
      special        <= 1'b0;
      special_result <= '0;
    end else if (en2) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        sign_big       <= big_c.sign;
        sign_small     <= small_c.sign;
        exp_big        <= big_c.exp_e;
        mant_big       <= big_c.mant;
        mant_small     <= small_c.mant;
        shift_amt      <= shift_c;
        eff_sub        <= big_c.sign ^ small_c.sign;
        special        <= special_c;
        special_result <= special_res_c;
      end
    end
  end

endmodule

// File: doc/fadd_unpack.md
Name: fadd_unpack

Overview:
Front-end operand stage of the single-precision FP add/sub pipeline, mirroring the final packing stage at the opposite end of the datapath. It accepts two raw IEEE-754 binary32 words and unpacks each into sign, exponent and hidden-bit mantissa. It classifies special operands, orders the operands by magnitude, and computes the alignment shift. The result goes downstream through a 2-stage valid/ready pipeline with backpressure.

Parameters:
SHIFT_MAX, 26, saturation value for the alignment shift amount (mantissa width + guard/round bits)
SHW, 5, width of the shift_amt output

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  stage accepts operands this cycle
op_a  input  32  operand A, binary32
op_b  input  32  operand B, binary32
sub  input  1  1 = compute A-B (invert effective sign of B)
out_valid  output  1  unpacked result valid
out_ready  input  1  downstream accepts result
sign_big  output  1  sign of larger-magnitude operand (effective)
sign_small  output  1  sign of smaller-magnitude operand (effective)
exp_big  output  8  effective exponent of larger operand
mant_big  output  24  {hidden,frac} of larger operand
mant_small  output  24  {hidden,frac} of smaller operand
shift_amt  output  SHW  min(exp_big-exp_small, SHIFT_MAX)
eff_sub  output  1  sign_big XOR sign_small
special  output  1  result fully determined by special-case logic
special_result  output  32  packed result when special=1, else 0

Behaviour:
- Reset (rst=1 at a clock edge): both stage valid bits cleared and all output registers zeroed: out_valid=0, every data output=0. in_ready=1 in the cycle after reset. rst overrides any transfer in the same cycle; in-flight data is discarded.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Stage-2 enable en2 = !out_valid | out_ready.
  - Stage-1 enable en1 = !s1_valid | en2.
  - in_ready = en1, combinational from registered state and out_ready.
  - Full throughput: one operation per cycle when out_ready=1.
  - Outputs hold stable while out_valid & !out_ready.
- Latency: 2 cycles from input transfer to out_valid when there is no backpressure.
- Stage 1 (unpack, registered on en1):
  - Effective sign of B = op_b[31] ^ sub.
  - Exponent field 0: hidden bit 0, effective exponent 1 (denormal/zero).
  - Otherwise: hidden bit 1, effective exponent = field.
  - Flags per operand: zero (exp=0, frac=0), inf (exp=255, frac=0), nan (exp=255, frac!=0).
- Stage 2 (order/classify, registered on en2):
  - Magnitude compare on {exp field, frac} of A vs B. A is "big" if magnitude A >= B; on a tie, A is big.
  - shift_amt = exp_big - exp_small (effective exponents), saturated to SHIFT_MAX.
  - eff_sub = sign_big ^ sign_small.
- Special-case priority:
  1. Either operand NaN -> special=1, special_result=32'h7FC00000.
  2. Both inf and effective signs differ -> special=1, special_result=32'h7FC00000.
  3. Exactly one inf, or both inf with the same effective sign -> special=1, special_result = {that sign, 8'hFF, 23'd0}.
  4. Both zero -> special=1, special_result = {signA & signB_eff, 31'd0}.
  5. Otherwise special=0, special_result=0.
- When special=1, the datapath fields still carry the unpacked values; downstream selects on special.
- Simultaneous events:
  - If s1 holds data, out_valid=1 and out_ready=1, the new input is accepted in the same cycle; no bubble.
  - If s1 and s2 are both full with out_ready=0, in_ready=0.

Test Plan:
- op_a=3F800000, op_b=40000000, sub=0 -> after 2 cycles: exp_big=0x80, mant_big=0x800000, mant_small=0x800000, shift_amt=1, sign_big=0, eff_sub=0, special=0.
- op_a=3F800000, op_b=3F800000, sub=1 -> sign_big=0 (A, tie), sign_small=1, eff_sub=1, shift_amt=0, special=0.
- op_a=7F800000, op_b=7F800000, sub=1 -> special=1, special_result=7FC00000; separately op_a=7FC00001 with any op_b -> 7FC00000.
- op_a=00000001, op_b=3F800000 -> mant_small=0x000001, exp_big=0x7F, shift_amt=26 (saturated from 126); op_a=op_b=80000000 -> special_result=80000000.
- Stream 4 ops with out_ready held 0 from cycle 2 -> in_ready drops after 2 accepted; out data stable. Release out_ready -> all 4 emerge in order, one per cycle.
- Assert rst with both stages full -> next cycle out_valid=0, all outputs 0, in_ready=1; a subsequent op completes with 2-cycle latency.
